truth_table_sweeper: RTL

//   Hardware self-check for an IN_W-input / OUT_W-output combinational function.
//   - On start, steps stim through every input code 0..2^IN_W-1.
//   - Waits SETTLE_CYC cycles per code, then samples resp and compares it

---
 rtl/truth_table_sweeper.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// On-board self-check for a small combinational function. When started, it
// drives every input code 0..2^IN_W-1 on stim. Each code is held for
// SETTLE_CYC cycles, and then resp is compared against the EXPECTED truth
// table. Results are reported as pass/fail, the first failing code with the
// value received there, and the total number of mismatching codes.
//
// Configuration macro:
//   SWEEP_ALL_EN  when defined, a mismatch does not stop the sweep and every
//                 code is checked. When undefined, the sweep ends at the
//                 first mismatch.
//
// Ports:
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous, active-low reset
//   start     in   1       begin a sweep (accepted only in IDLE or DONE)
//   stim      out  IN_W    registered code driven to the function under test
//   resp      in   OUT_W   function output, sampled in CHECK
//   busy      out  1       high while sweeping (SETTLE or CHECK)
//   done      out  1       high in DONE until the next accepted start/reset
//   pass      out  1       valid while done=1, 1 means every code matched
//   fail_idx  out  IN_W    first mismatching code, 0 if none
//   fail_got  out  OUT_W   resp value captured at fail_idx
//   err_cnt   out  IN_W+1  number of mismatching codes
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int                        IN_W       = 4,
    parameter int                        OUT_W      = 1,
    parameter logic [(OUT_W<<IN_W)-1:0]  EXPECTED   = 16'hAAEA,
    parameter int                        SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W-1:0]  fail_idx,
    output logic [OUT_W-1:0] fail_got,
    output logic [IN_W:0]    err_cnt
);

    localparam int                NUM_CODES = 1 << IN_W;
    localparam int                ERR_W     = IN_W + 1;
    localparam int                CNT_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IN_W-1:0]   IDX_LAST  = {IN_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t             state_q,   state_d;
    logic [IN_W-1:0]    stim_q,    stim_d;
    logic [IN_W-1:0]    idx_q,     idx_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               done_q,    done_d;
    logic               pass_q,    pass_d;
    logic [IN_W-1:0]    failIdx_q, failIdx_d;
    logic [OUT_W-1:0]   failGot_q, failGot_d;
    logic [ERR_W-1:0]   errCnt_q,  errCnt_d;

    logic [OUT_W-1:0]   expTab [NUM_CODES];
    logic               respMismatch;
    logic               earlyExit;

    // Unpack the flat EXPECTED vector into one entry per code, so the table
    // can be indexed directly by the IN_W-bit code index.
    for (genvar k = 0; k < NUM_CODES; k++) begin : g_expTab
        assign expTab[k] = EXPECTED[k*OUT_W +: OUT_W];
    end

    // The comparison only means anything in CHECK. Outside CHECK it is
    // ignored by the next-state logic.
    assign respMismatch = (resp != expTab[idx_q]);

    // A mismatch ends the sweep unless the build asks for a full sweep.
`ifdef SWEEP_ALL_EN
    assign earlyExit = 1'b0;
`else
    assign earlyExit = respMismatch;
`endif

    // Next-state and result logic. Every register holds its value unless a
    // state explicitly updates it. A start seen in IDLE or DONE clears the
    // previous result and launches a sweep from code 0.
    always_comb begin
        state_d   = state_q;
        stim_d    = stim_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        pass_d    = pass_q;
        failIdx_d = failIdx_q;
        failGot_d = failGot_q;
        errCnt_d  = errCnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    stim_d    = '0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    failIdx_d = '0;
                    failGot_d = '0;
                    errCnt_d  = '0;
                end
            end

            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CHECK: begin
                if (respMismatch) begin
                    if (errCnt_q == '0) begin
                        failIdx_d = idx_q;
                        failGot_d = resp;
                    end
                    errCnt_d = errCnt_q + ERR_W'(1);
                end

                if (earlyExit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (idx_q == IDX_LAST) begin
                    // The current code's outcome is folded in here, because
                    // errCnt_q does not include it yet.
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (errCnt_q == '0) && !respMismatch;
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx_q + IN_W'(1);
                    stim_d  = idx_q + IN_W'(1);
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers. Reset returns to IDLE immediately, and no
    // partial sweep result survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stim_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            failIdx_q <= '0;
            failGot_q <= '0;
            errCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            failIdx_q <= failIdx_d;
            failGot_q <= failGot_d;
            errCnt_q  <= errCnt_d;
        end
    end

    assign busy     = (state_q == SETTLE) || (state_q == CHECK);
    assign stim     = stim_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_idx = failIdx_q;
    assign fail_got = failGot_q;
    assign err_cnt  = errCnt_q;

endmodule
